// File: rtl/tri_pkg.sv
// -----------------------------------------------------------------------------
// tri_pkg: types and constants shared by the triangle fetch block.
//   vertex_t      : three 9-bit coordinates. Element k is coordinate k, and the
//                   packed bit layout is identical to the 27-bit vertex word.
//   C*_LSB        : field offsets of each coordinate inside the vertex word.
//   state_t       : fetch FSM states.
//   rd_tag_t      : tag attached to an outstanding BRAM read.
//   unpack_vertex : splits a 27-bit vertex word into a vertex_t.
// -----------------------------------------------------------------------------
package tri_pkg;

  localparam int COORD_W    = 9;
  localparam int VTX_WORD_W = 3 * COORD_W;
  localparam int C0_LSB     = 0;
  localparam int C1_LSB     = 9;
  localparam int C2_LSB     = 18;

  typedef logic [2:0][COORD_W-1:0] vertex_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IDX_RD,
    S_VTX_RD,
    S_PRESENT,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    TAG_NONE,
    TAG_IDX,
    TAG_V1,
    TAG_V2,
    TAG_V3
  } rd_tag_t;

  function automatic vertex_t unpack_vertex(input logic [VTX_WORD_W-1:0] word);
    vertex_t v;
    v[0] = word[C0_LSB +: COORD_W];
    v[1] = word[C1_LSB +: COORD_W];
    v[2] = word[C2_LSB +: COORD_W];
    return v;
  endfunction

endpackage

// File: rtl/rd_lat_tracker.sv
// -----------------------------------------------------------------------------
// rd_lat_tracker: follows BRAM reads through their fixed read latency.
// The tag of the address currently on a BRAM address bus enters the pipe; it
// leaves RD_LAT cycles later, in the cycle the matching data is on the bus.
//   clk         : clock
//   rst         : asynchronous, active-high reset; clears every tag
//   issue_tag   : tag of the address presented this cycle (TAG_NONE if none)
//   capture_tag : tag of the read whose data is on the bus this cycle
// -----------------------------------------------------------------------------
module rd_lat_tracker
  import tri_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t issue_tag,
  output rd_tag_t capture_tag
);

  rd_tag_t pipe [RD_LAT];

  // NOTE: this small array is reset deliberately; clearing the tags is what
  // makes data from reads abandoned by a reset arrive untagged and be ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= TAG_NONE;
    end else begin
      pipe[0] <= issue_tag;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign capture_tag = pipe[RD_LAT-1];

endmodule

// File: rtl/tri_fetch.sv
// -----------------------------------------------------------------------------
// tri_fetch: per frame, walks the index BRAM, reads three vertices per entry
// from the vertex BRAM and hands triangles to the rasterizer one at a time.
//   clk_in, rst_in      : pixel clock, asynchronous active-high reset
//   new_frame_in        : one-cycle frame start (honoured only when idle)
//   idx_addr_out        : index BRAM address (registered)
//   idx_data_in         : {i1,i2,i3}, i1 in the MSBs
//   vtx_addr_out        : vertex BRAM address (registered)
//   vtx_data_in         : 27-bit vertex word
//   vert1/2/3_out       : triangle vertices, held until the next capture
//   valid_tri_out       : triangle valid; ready_in accepts it
//   obj_done_out        : one-cycle pulse when the frame's list is finished
//   busy_out            : high from frame start until obj_done
//   drop_count_out      : saturating count of dropped triangles this frame
// An entry with any vertex index >= NUM_VERTICES is dropped without vertex
// reads and the walk continues as if it had been accepted.
// -----------------------------------------------------------------------------
module tri_fetch
  import tri_pkg::*;
#(
  parameter int NUM_VERTICES = 8,
  parameter int NUM_TRIS     = 12,
  parameter int RD_LAT       = 2,
  parameter int IDX_W        = $clog2(NUM_VERTICES)
) (
  input  logic                                                clk_in,
  input  logic                                                rst_in,
  input  logic                                                new_frame_in,
  output logic [((NUM_TRIS > 1) ? $clog2(NUM_TRIS) : 1)-1:0]  idx_addr_out,
  input  logic [3*IDX_W-1:0]                                  idx_data_in,
  output logic [IDX_W-1:0]                                    vtx_addr_out,
  input  logic [26:0]                                         vtx_data_in,
  output logic [2:0][8:0]                                     vert1_out,
  output logic [2:0][8:0]                                     vert2_out,
  output logic [2:0][8:0]                                     vert3_out,
  output logic                                                valid_tri_out,
  input  logic                                                ready_in,
  output logic                                                obj_done_out,
  output logic                                                busy_out,
  output logic [7:0]                                          drop_count_out
);

  localparam int               TRI_W     = (NUM_TRIS > 1) ? $clog2(NUM_TRIS) : 1;
  localparam logic [TRI_W-1:0] LAST_TRI  = TRI_W'(NUM_TRIS - 1);
  localparam logic [IDX_W:0]   VTX_LIMIT = (IDX_W + 1)'(NUM_VERTICES);

  state_t           state;
  logic [TRI_W-1:0] tri_idx;
  logic [IDX_W-1:0] idx1, idx2, idx3;
  logic [IDX_W-1:0] idx2_q, idx3_q;
  logic             idx_capture, idx_bad, tri_retired;
  rd_tag_t          issue_tag, capture_tag;

  rd_lat_tracker #(.RD_LAT(RD_LAT)) u_tracker (
    .clk         (clk_in),
    .rst         (rst_in),
    .issue_tag   (issue_tag),
    .capture_tag (capture_tag)
  );

  // NOTE: every signal below is assigned on every path through the block, so
  // this stays purely combinational with no inferred latch.
  always_comb begin
    {idx1, idx2, idx3} = idx_data_in;
    idx_bad     = ({1'b0, idx1} >= VTX_LIMIT) || ({1'b0, idx2} >= VTX_LIMIT) ||
                  ({1'b0, idx3} >= VTX_LIMIT);
    idx_capture = (state == S_IDX_RD) && (capture_tag == TAG_IDX);
    // A triangle is retired either by a handshake or by being dropped.
    tri_retired = (idx_capture && idx_bad) || (valid_tri_out && ready_in);
  end

  // NOTE: all state here is updated with non-blocking assignments, so the
  // per-cycle defaults at the top and later overrides resolve as last-wins
  // without ordering hazards between reads and writes.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      tri_idx        <= '0;
      idx2_q         <= '0;
      idx3_q         <= '0;
      issue_tag      <= TAG_NONE;
      idx_addr_out   <= '0;
      vtx_addr_out   <= '0;
      vert1_out      <= '0;
      vert2_out      <= '0;
      vert3_out      <= '0;
      valid_tri_out  <= 1'b0;
      obj_done_out   <= 1'b0;
      busy_out       <= 1'b0;
      drop_count_out <= '0;
    end else begin
      issue_tag    <= TAG_NONE;
      obj_done_out <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (new_frame_in) begin
            tri_idx        <= '0;
            idx_addr_out   <= '0;
            issue_tag      <= TAG_IDX;
            drop_count_out <= '0;
            busy_out       <= 1'b1;
            state          <= S_IDX_RD;
          end
        end

        S_IDX_RD: begin
          if (idx_capture) begin
            if (idx_bad) begin
              if (drop_count_out != 8'hFF) drop_count_out <= drop_count_out + 8'd1;
            end else begin
              vtx_addr_out <= idx1;
              idx2_q       <= idx2;
              idx3_q       <= idx3;
              issue_tag    <= TAG_V1;
              state        <= S_VTX_RD;
            end
          end
        end

        S_VTX_RD: begin
          // Issue the remaining two addresses back to back after i1.
          case (issue_tag)
            TAG_V1: begin
              vtx_addr_out <= idx2_q;
              issue_tag    <= TAG_V2;
            end
            TAG_V2: begin
              vtx_addr_out <= idx3_q;
              issue_tag    <= TAG_V3;
            end
            default: ;
          endcase
          case (capture_tag)
            TAG_V1: vert1_out <= unpack_vertex(vtx_data_in);
            TAG_V2: vert2_out <= unpack_vertex(vtx_data_in);
            TAG_V3: begin
              vert3_out     <= unpack_vertex(vtx_data_in);
              valid_tri_out <= 1'b1;
              state         <= S_PRESENT;
            end
            default: ;
          endcase
        end

        S_PRESENT: begin
          if (ready_in) valid_tri_out <= 1'b0;
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase

      if (tri_retired) begin
        if (tri_idx == LAST_TRI) begin
          obj_done_out <= 1'b1;
          busy_out     <= 1'b0;
          state        <= S_DONE;
        end else begin
          tri_idx      <= tri_idx + 1'b1;
          idx_addr_out <= tri_idx + 1'b1;
          issue_tag    <= TAG_IDX;
          state        <= S_IDX_RD;
        end
      end
    end
  end

endmodule
